// File: rtl/change_dispenser.sv
// Coin change dispenser: pays `amount` 5-rupee units through the 5/10-rupee hoppers, with a per-coin jam timeout.
// Optional macro CHANGE_DISPENSER_TEN_HOPPER_EN enables greedy use of the 10-rupee hopper.
module change_dispenser #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] amount,
  input  logic       coin_sense,
  input  logic       clr,
  output logic       drop5,
  output logic       drop10,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] left,
  output logic [2:0] state_dbg
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    left_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          coin10, coin10_nxt;
  logic          ten_ok;

`ifdef CHANGE_DISPENSER_TEN_HOPPER_EN
  assign ten_ok = (left >= 4'd2);
`else
  assign ten_ok = 1'b0;
`endif

  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    left_nxt   = left;
    timer_nxt  = timer;
    coin10_nxt = coin10;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          left_nxt  = amount;
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        timer_nxt = '0;
        if (left == 4'd0) begin
          state_nxt = S_DONE;
        end else begin
          coin10_nxt = ten_ok;
          state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A sensed coin takes priority over the timeout expiring in the same cycle.
        if (coin_sense) begin
          left_nxt  = left - (coin10 ? 4'd2 : 4'd1);
          state_nxt = S_SELECT;
        end else if (timer == TMAX) begin
          state_nxt = S_ERR;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_DONE: state_nxt = S_IDLE;
      S_ERR: begin
        if (clr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered images of the next state, so they align with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      left   <= 4'd0;
      timer  <= '0;
      coin10 <= 1'b0;
      drop5  <= 1'b0;
      drop10 <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      left   <= left_nxt;
      timer  <= timer_nxt;
      coin10 <= coin10_nxt;
      drop5  <= (state_nxt == S_WAIT) && !coin10_nxt;
      drop10 <= (state_nxt == S_WAIT) && coin10_nxt;
      busy   <= (state_nxt == S_SELECT) || (state_nxt == S_WAIT) || (state_nxt == S_DONE);
      done   <= (state_nxt == S_DONE);
      err    <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a coin-level model predicts drop/done/err events,
// a negedge monitor compares what the DUT presents; drivers also check latencies and fault handling.
module tb_change_dispenser;

  localparam int TIMEOUT = 15;
  localparam logic [3:0] EV_DROP5 = 4'd1, EV_DROP10 = 4'd2, EV_DONE = 4'd3, EV_ERR = 4'd4;
`ifdef CHANGE_DISPENSER_TEN_HOPPER_EN
  localparam bit TEN_EN = 1'b1;
`else
  localparam bit TEN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, req, coin_sense, clr;
  logic [3:0] amount;
  logic       drop5, drop10, busy, done, err;
  logic [3:0] left;
  logic [2:0] state_dbg;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  change_dispenser #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .amount(amount), .coin_sense(coin_sense), .clr(clr),
    .drop5(drop5), .drop10(drop10), .busy(busy), .done(done), .err(err), .left(left),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // reference model: coin-by-coin payout of the owed amount
  function automatic int coin_count(input int amt);
    int r, n;
    r = amt;
    n = 0;
    while (r > 0) begin
      r -= (TEN_EN && r >= 2) ? 2 : 1;
      n++;
    end
    return n;
  endfunction

  task automatic model_push(input int amt, input int jam_idx, output int rem_out);
    int r, n, c;
    r = amt;
    n = 0;
    rem_out = 0;
    while (r > 0) begin
      c = (TEN_EN && r >= 2) ? 2 : 1;
      exp_q.push_back({(c == 2) ? EV_DROP10 : EV_DROP5, 4'(r)});
      if (n == jam_idx) begin
        exp_q.push_back({EV_ERR, 4'(r)});
        rem_out = r;
        return;
      end
      r -= c;
      n++;
    end
    exp_q.push_back({EV_DONE, 4'd0});
  endtask

  // monitor: rising edges of drop/done/err are events checked against the queue
  logic p5 = 1'b0, p10 = 1'b0, pd = 1'b0, pe = 1'b0;

  task automatic observe(input logic [7:0] ev);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("event_unexpected", int'(ev), -1);
    end else begin
      e = exp_q.pop_front();
      check("event", int'(ev), int'(e));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (drop5 && !p5)   observe({EV_DROP5, left});
      if (drop10 && !p10) observe({EV_DROP10, left});
      if (done && !pd)    observe({EV_DONE, left});
      if (err && !pe)     observe({EV_ERR, left});
    end
    p5  = drop5;
    p10 = drop10;
    pd  = done;
    pe  = err;
  end

  // driver: one change request, with optional jam on coin jam_idx (-1 = none)
  task automatic dispense(input int amt, input int jam_idx, input int dly_fix, input bit noise);
    int rem, k, w, t0, dly;
    model_push(amt, jam_idx, rem);
    req = 1'b1;
    amount = 4'(amt);
    t0 = cyc;
    step();
    req = 1'b0;
    if (noise) amount = 4'($urandom_range(0, 15));
    k = 0;
    while (k < 20) begin
      w = 0;
      while (!(drop5 || drop10) && !done && w < 12) begin
        step();
        w++;
      end
      if (done) break;
      if (!(drop5 || drop10)) begin
        check("drop_wait_timeout", 0, 1);
        return;
      end
      if (k == 0) begin
        check("first_drop_latency", cyc - t0, 2);
        check("busy_in_wait", busy, 1);
      end
      if (!TEN_EN) check("drop10_unused", drop10, 0);
      if (k == jam_idx) begin
        t0 = cyc;
        w = 0;
        while (!err && w < TIMEOUT + 5) begin
          step();
          w++;
        end
        check("jam_err_latency", cyc - t0, TIMEOUT + 1);
        check("jam_left", left, rem);
        req = 1'b1;
        amount = 4'($urandom_range(1, 15));
        step();
        req = 1'b0;
        check("err_ignores_req", {err, busy, drop5, drop10}, 4'b1000);
        coin_sense = 1'b1;
        step();
        coin_sense = 1'b0;
        check("err_ignores_coin", left, rem);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_err", err, 0);
        check("clr_left", left, rem);
        check("clr_busy", busy, 0);
        coin_sense = 1'b1;
        step();
        coin_sense = 1'b0;
        check("idle_ignores_coin", left, rem);
        return;
      end
      dly = (dly_fix < 0) ? int'($urandom_range(0, 5)) : dly_fix;
      repeat (dly) begin
        if (noise) begin
          req = 1'($urandom_range(0, 1));
          amount = 4'($urandom_range(0, 15));
        end
        step();
      end
      req = 1'b0;
      coin_sense = 1'b1;
      step();
      coin_sense = 1'b0;
      check("drop_gap", drop5 | drop10, 0);
      check("no_err_after_coin", err, 0);
      k++;
    end
    if (!done) begin
      check("done_wait_timeout", 0, 1);
      return;
    end
    if (amt == 0) check("zero_done_latency", cyc - t0, 2);
    check("done_left", left, 0);
    check("done_busy", busy, 1);
    step();
    check("idle_busy", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int rem, w;
    reset = 1'b0;
    req = 1'b0;
    amount = 4'd0;
    coin_sense = 1'b0;
    clr = 1'b0;
    step();
    step();
    check("rst_outputs", {drop5, drop10, busy, done, err}, 0);
    check("rst_left", left, 0);
    reset = 1'b1;

    // directed: amount 3 with coin 3 cycles after each drop
    dispense(3, -1, 3, 1'b0);
    // amount 0: done only
    dispense(0, -1, 0, 1'b0);
    // amount 2, never sensed: jam
    dispense(2, 0, 0, 1'b0);
    // coin sensed on the timeout cycle still pays
    dispense(1, -1, TIMEOUT, 1'b0);
    dispense(2, -1, TIMEOUT, 1'b0);

    // reset mid-WAIT
    model_push(5, -1, rem);
    req = 1'b1;
    amount = 4'd5;
    step();
    req = 1'b0;
    w = 0;
    while (!(drop5 || drop10) && w < 12) begin
      step();
      w++;
    end
    check("rst_mid_drop_seen", drop5 | drop10, 1);
    step();
    step();
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outputs", {drop5, drop10, busy, done, err}, 0);
    check("rst_mid_left", left, 0);
    exp_q.delete();
    step();
    reset = 1'b1;
    dispense(1, -1, 2, 1'b0);

    // random requests with noise on req/amount while busy and occasional jams
    for (int i = 0; i < 25; i++) begin
      int a, j, n;
      a = $urandom_range(0, 15);
      n = coin_count(a);
      j = (n > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      dispense(a, j, -1, 1'b1);
    end

    step();
    step();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
